ip_hdr_checksum_ttl: RTL and testbench

IP_HDR_CHECKSUM_TTL -- requirements
Module: ip_hdr_checksum_ttl

---
 rtl/ip_hdr_checksum_ttl.sv | 203 ++++++++++++++++++++
 tb/tb_ip_hdr_checksum_ttl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_hdr_checksum_ttl.sv
`default_nettype none
// =====================================================================
// Module  : ip_hdr_checksum_ttl
// Purpose : Passive stream tap that verifies the IPv4 header checksum,
//           derives the decremented TTL and the matching checksum, and
//           queues one result per packet in a first-word-fallthrough FIFO.
// Revision: 1.0
// =====================================================================
module ip_hdr_checksum_ttl #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] in_tdata,
    input  logic                           in_tlast,
    input  logic                           in_tvalid,
    input  logic                           in_tready,
    input  logic                           rd_check,
    output logic                           ip_checksum_vld,
    output logic                           ip_checksum_is_good,
    output logic                           ip_hdr_has_options,
    output logic                           ip_ttl_is_good,
    output logic [7:0]                     ip_new_ttl,
    output logic [15:0]                    ip_new_checksum,
    output logic                           info_fifo_overflow
);

    localparam int                            c_depth      = 1 << INFO_FIFO_DEPTH_BITS;
    localparam logic [INFO_FIFO_DEPTH_BITS:0] c_full_count = c_depth[INFO_FIFO_DEPTH_BITS:0];

    typedef enum logic [1:0] {
        ST_WORD0    = 2'd0,
        ST_WORD1    = 2'd1,
        ST_WAIT_EOP = 2'd2
    } state_t;

    typedef struct packed {
        logic        is_good;
        logic        has_options;
        logic        ttl_is_good;
        logic [7:0]  new_ttl;
        logic [15:0] new_checksum;
    } entry_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_beat;
    logic        w_push;
    logic        w_use_live;

    logic [7:0]  r_ver_ihl;
    logic [7:0]  r_ttl;
    logic [15:0] r_old_csum;
    logic [19:0] r_sum;

    logic [19:0] w_sum0;
    logic [19:0] w_sum_full;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    logic [7:0]  w_ver_ihl;
    logic [7:0]  w_ttl;
    logic [15:0] w_old_csum;
    logic [16:0] w_csum_add;
    entry_t      w_entry;

    entry_t                            r_mem [c_depth];
    logic [INFO_FIFO_DEPTH_BITS-1:0]   r_wr_ptr;
    logic [INFO_FIFO_DEPTH_BITS-1:0]   r_rd_ptr;
    logic [INFO_FIFO_DEPTH_BITS:0]     r_count;
    logic                              r_overflow;
    logic                              w_empty;
    logic                              w_full;
    logic                              w_pop;
    logic                              w_wr_en;

    // Ethernet padding bytes ahead of the IP header never feed any result.
    logic w_unused_bits;
    assign w_unused_bits = ^in_tdata[111:16];

    assign w_beat = in_tvalid & in_tready;

    // Header words 0..8 sit in bytes 14..31 of the first stream word.
    always_comb begin
        w_sum0 = '0;
        for (int i = 7; i < 16; i++) begin
            w_sum0 = w_sum0 + {4'b0000, in_tdata[16*i +: 8], in_tdata[16*i+8 +: 8]};
        end
    end

    assign w_sum_full = r_sum + {4'b0000, in_tdata[7:0], in_tdata[15:8]};
    assign w_fold1    = {1'b0, w_sum_full[15:0]} + {13'd0, w_sum_full[19:16]};
    assign w_fold2    = w_fold1[15:0] + {15'd0, w_fold1[16]};

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_use_live   = 1'b0;
        case (r_state)
            ST_WORD0: begin
                if (w_beat) begin
                    if (in_tlast) begin
                        w_push     = 1'b1;
                        w_use_live = 1'b1;
                    end else begin
                        w_next_state = ST_WORD1;
                    end
                end
            end
            ST_WORD1: begin
                if (w_beat) begin
                    w_push       = 1'b1;
                    w_next_state = in_tlast ? ST_WORD0 : ST_WAIT_EOP;
                end
            end
            ST_WAIT_EOP: begin
                if (w_beat && in_tlast) begin
                    w_next_state = ST_WORD0;
                end
            end
            default: w_next_state = ST_WORD0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WORD0;
            r_ver_ihl  <= 8'd0;
            r_ttl      <= 8'd0;
            r_old_csum <= 16'd0;
            r_sum      <= 20'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_WORD0 && w_beat) begin
                r_ver_ihl  <= in_tdata[119:112];
                r_ttl      <= in_tdata[183:176];
                r_old_csum <= {in_tdata[199:192], in_tdata[207:200]};
                r_sum      <= w_sum0;
            end
        end
    end

    // A runt packet has its header fields only on the live bus, not latched yet.
    assign w_ver_ihl  = w_use_live ? in_tdata[119:112] : r_ver_ihl;
    assign w_ttl      = w_use_live ? in_tdata[183:176] : r_ttl;
    assign w_old_csum = w_use_live ? {in_tdata[199:192], in_tdata[207:200]} : r_old_csum;
    assign w_csum_add = {1'b0, w_old_csum} + 17'h00100;

    always_comb begin
        w_entry.is_good      = w_use_live ? 1'b0 : (w_fold2 == 16'hFFFF);
        w_entry.has_options  = (w_ver_ihl != 8'h45);
        w_entry.ttl_is_good  = (w_ttl > 8'd1);
        w_entry.new_ttl      = (w_ttl == 8'd0) ? 8'd0 : (w_ttl - 8'd1);
        w_entry.new_checksum = w_csum_add[15:0] + {15'd0, w_csum_add[16]};
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    assign w_pop   = rd_check & ~w_empty;
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + INFO_FIFO_DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + INFO_FIFO_DEPTH_BITS'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + (INFO_FIFO_DEPTH_BITS + 1)'(1);
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - (INFO_FIFO_DEPTH_BITS + 1)'(1);
            end
            if (w_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ip_checksum_vld     = ~w_empty;
    assign ip_checksum_is_good = r_mem[r_rd_ptr].is_good;
    assign ip_hdr_has_options  = r_mem[r_rd_ptr].has_options;
    assign ip_ttl_is_good      = r_mem[r_rd_ptr].ttl_is_good;
    assign ip_new_ttl          = r_mem[r_rd_ptr].new_ttl;
    assign ip_new_checksum     = r_mem[r_rd_ptr].new_checksum;
    assign info_fifo_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ip_hdr_checksum_ttl.sv
`default_nettype none
// =====================================================================
// Module  : tb_ip_hdr_checksum_ttl
// Purpose : Directed scoreboard bench for ip_hdr_checksum_ttl.
// Revision: 1.0
// =====================================================================
module tb_ip_hdr_checksum_ttl;

    logic         clk;
    logic         reset;
    logic [255:0] in_tdata;
    logic         in_tlast;
    logic         in_tvalid;
    logic         in_tready;
    logic         rd_check;
    logic         ip_checksum_vld;
    logic         ip_checksum_is_good;
    logic         ip_hdr_has_options;
    logic         ip_ttl_is_good;
    logic [7:0]   ip_new_ttl;
    logic [15:0]  ip_new_checksum;
    logic         info_fifo_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_good;
        logic        has_options;
        logic        ttl_is_good;
        logic [7:0]  new_ttl;
        logic [15:0] new_checksum;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] hdr [20];

    ip_hdr_checksum_ttl #(
        .C_S_AXIS_DATA_WIDTH (256),
        .INFO_FIFO_DEPTH_BITS(2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_tdata           (in_tdata),
        .in_tlast           (in_tlast),
        .in_tvalid          (in_tvalid),
        .in_tready          (in_tready),
        .rd_check           (rd_check),
        .ip_checksum_vld    (ip_checksum_vld),
        .ip_checksum_is_good(ip_checksum_is_good),
        .ip_hdr_has_options (ip_hdr_has_options),
        .ip_ttl_is_good     (ip_ttl_is_good),
        .ip_new_ttl         (ip_new_ttl),
        .ip_new_checksum    (ip_new_checksum),
        .info_fifo_overflow (info_fifo_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void set_base();
        hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    endfunction

    function automatic logic [255:0] make_word0();
        logic [255:0] w;
        w = rand256();
        w[103:96]  = 8'h08;
        w[111:104] = 8'h00;
        for (int k = 14; k < 32; k++) w[8*k +: 8] = hdr[k-14];
        return w;
    endfunction

    function automatic logic [255:0] make_word1();
        logic [255:0] w;
        w = rand256();
        w[7:0]  = hdr[18];
        w[15:8] = hdr[19];
        return w;
    endfunction

    function automatic exp_t model_entry(input bit runt);
        exp_t        e;
        int unsigned s;
        logic [16:0] c;
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0000, hdr[2*i], hdr[2*i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        e.is_good     = !runt && (s == 32'hFFFF);
        e.has_options = (hdr[0] != 8'h45);
        e.ttl_is_good = (hdr[8] > 8'd1);
        e.new_ttl     = (hdr[8] == 8'h00) ? 8'h00 : hdr[8] - 8'h01;
        c = {1'b0, hdr[10], hdr[11]} + 17'h00100;
        if (c > 17'h0FFFF) c = c - 17'h0FFFF;
        e.new_checksum = c[15:0];
        return e;
    endfunction

    task automatic drive_beat(input logic [255:0] data, input logic last, input logic pop);
        in_tdata  = data;
        in_tlast  = last;
        in_tvalid = 1'b1;
        in_tready = 1'b1;
        rd_check  = pop;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        rd_check  = 1'b0;
    endtask

    // Valid word the downstream refuses: must not count as a beat.
    task automatic drive_stall();
        in_tdata  = rand256();
        in_tlast  = 1'b1;
        in_tvalid = 1'b1;
        in_tready = 1'b0;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tready = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_head(input string tag, input bit do_pop);
        exp_t e;
        check({tag, "_vld"}, {31'd0, ip_checksum_vld}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_is_good"}, {31'd0, ip_checksum_is_good}, {31'd0, e.is_good});
            check({tag, "_has_opt"}, {31'd0, ip_hdr_has_options}, {31'd0, e.has_options});
            check({tag, "_ttl_ok"},  {31'd0, ip_ttl_is_good},     {31'd0, e.ttl_is_good});
            check({tag, "_new_ttl"}, {24'd0, ip_new_ttl},         {24'd0, e.new_ttl});
            check({tag, "_new_cs"},  {16'd0, ip_new_checksum},    {16'd0, e.new_checksum});
        end
        if (do_pop) begin
            rd_check = 1'b1;
            @(posedge clk);
            #1;
            rd_check = 1'b0;
        end
    endtask

    task automatic send_pkt(input int nbeats, input bit keep, input bit pop_last);
        logic [255:0] w0;
        logic [255:0] w1;
        w0 = make_word0();
        w1 = make_word1();
        if (nbeats == 1) begin
            if (keep) sb.push_back(model_entry(1'b1));
            drive_beat(w0, 1'b1, 1'b0);
        end else begin
            drive_beat(w0, 1'b0, 1'b0);
            if (pop_last) check_head("concurrent", 1'b0);
            if (keep) sb.push_back(model_entry(1'b0));
            drive_beat(w1, (nbeats == 2), pop_last);
            for (int b = 2; b < nbeats; b++) drive_beat(rand256(), (b == nbeats - 1), 1'b0);
        end
    endtask

    initial begin
        logic [255:0] w0;
        logic [255:0] w1;
        reset     = 1'b1;
        in_tdata  = '0;
        in_tlast  = 1'b0;
        in_tvalid = 1'b0;
        in_tready = 1'b1;
        rd_check  = 1'b0;
        apply_reset();
        check("reset_vld", {31'd0, ip_checksum_vld}, 32'd0);
        check("reset_ovf", {31'd0, info_fifo_overflow}, 32'd0);

        // Reference header, 3 beats with a refused word between 0 and 1.
        set_base();
        w0 = make_word0();
        w1 = make_word1();
        sb.push_back(exp_t'{1'b1, 1'b0, 1'b1, 8'h3F, 16'hB961});
        drive_beat(w0, 1'b0, 1'b0);
        drive_stall();
        check("A_vld_early", {31'd0, ip_checksum_vld}, 32'd0);
        drive_beat(w1, 1'b0, 1'b0);
        check("A_latency", {31'd0, ip_checksum_vld}, 32'd1);
        drive_beat(rand256(), 1'b1, 1'b0);
        check_head("A", 1'b1);
        check("A_one_entry", {31'd0, ip_checksum_vld}, 32'd0);

        // Header field variants.
        set_base(); hdr[11] = 8'h62; send_pkt(2, 1'b1, 1'b0);
        set_base(); hdr[8]  = 8'h01; send_pkt(3, 1'b1, 1'b0);
        set_base(); hdr[8]  = 8'h00; send_pkt(2, 1'b1, 1'b0);
        check_head("bad_cs", 1'b1);
        check_head("ttl01", 1'b1);
        check_head("ttl00", 1'b1);
        set_base(); hdr[0] = 8'h46; send_pkt(2, 1'b1, 1'b0);
        set_base(); hdr[10] = 8'hFF; hdr[11] = 8'hFF; send_pkt(4, 1'b1, 1'b0);
        check_head("opts", 1'b1);
        check_head("cs_ffff", 1'b1);
        check("var_drained", {31'd0, ip_checksum_vld}, 32'd0);

        // Pop while empty is ignored.
        rd_check = 1'b1;
        @(posedge clk);
        #1;
        rd_check = 1'b0;
        check("empty_pop", {31'd0, ip_checksum_vld}, 32'd0);

        // Runt packet followed by a normal one.
        set_base(); send_pkt(1, 1'b1, 1'b0);
        set_base(); hdr[8] = 8'h20; send_pkt(2, 1'b1, 1'b0);
        check_head("runt", 1'b1);
        check_head("after_runt", 1'b1);
        check("runt_drained", {31'd0, ip_checksum_vld}, 32'd0);
        check("no_ovf_yet", {31'd0, info_fifo_overflow}, 32'd0);

        // Five packets into a 4-entry FIFO with no reads.
        for (int p = 0; p < 5; p++) begin
            set_base(); hdr[8] = 8'h10 + 8'(p);
            send_pkt(2, (p < 4), 1'b0);
        end
        check("ovf_set", {31'd0, info_fifo_overflow}, 32'd1);
        for (int p = 0; p < 4; p++) check_head("ovf_order", 1'b1);
        check("ovf_drained", {31'd0, ip_checksum_vld}, 32'd0);
        check("ovf_sticky", {31'd0, info_fifo_overflow}, 32'd1);

        // Full FIFO with a pop coinciding with the push.
        apply_reset();
        check("ovf_cleared", {31'd0, info_fifo_overflow}, 32'd0);
        for (int p = 0; p < 4; p++) begin
            set_base(); hdr[8] = 8'h30 + 8'(p);
            send_pkt(2, 1'b1, 1'b0);
        end
        set_base(); hdr[8] = 8'h34;
        send_pkt(2, 1'b1, 1'b1);
        check("full_pop_push_ovf", {31'd0, info_fifo_overflow}, 32'd0);
        for (int p = 0; p < 4; p++) check_head("full_pop_order", 1'b1);
        check("full_pop_drained", {31'd0, ip_checksum_vld}, 32'd0);

        // Reset in the middle of a packet.
        set_base(); send_pkt(2, 1'b1, 1'b0);
        set_base(); drive_beat(make_word0(), 1'b0, 1'b0);
        apply_reset();
        sb.delete();
        check("midrst_vld", {31'd0, ip_checksum_vld}, 32'd0);
        set_base(); hdr[8] = 8'h05; send_pkt(2, 1'b1, 1'b0);
        check_head("midrst_pkt", 1'b1);
        check("midrst_single", {31'd0, ip_checksum_vld}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
